// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared SHA-1 constants, FSM encoding and byte packing helper
package sha1_pkg;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hEFCDAB89;
    localparam logic [31:0] H2 = 32'h98BADCFE;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hC3D2E1F0;

    localparam int BLOCK_BITS     = 512;
    localparam int MIN_MSG_BYTES  = 56;
    localparam int MAX_MSG_BYTES  = 119;
    localparam int LEN_FIELD_BYTE = 120;
    localparam int BUF_BYTES      = 128;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_PAD     = 3'd3;
    localparam logic [2:0] ST_START   = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;
    localparam logic [2:0] ST_OUT     = 3'd6;

    // Lowest bit of padded byte k in the core's two-block word; first byte of a word is its MSB.
    function automatic int byte_bit_lo(input int k);
        return BLOCK_BITS * (k / 64) + 32 * ((k % 64) / 4) + 8 * (3 - (k % 4));
    endfunction

endpackage

// File: rtl/sha1_pad_pack.sv
// rtl/sha1_pad_pack.sv - combinational FIPS 180-4 two-block padding and packing
module sha1_pad_pack
    import sha1_pkg::*;
(
    input  logic [8*BUF_BYTES-1:0] buf_i,
    input  logic [6:0]             len_i,
    output logic [8*BUF_BYTES-1:0] data_o
);

    logic [63:0] bit_len;
    logic [7:0]  pad_byte;

    assign bit_len = {54'd0, len_i, 3'd0};

    always_comb begin
        data_o   = '0;
        pad_byte = '0;
        for (int k = 0; k < BUF_BYTES; k++) begin
            if (k < int'(len_i)) begin
                pad_byte = buf_i[8*k +: 8];
            end else if (k == int'(len_i)) begin
                pad_byte = 8'h80;
            end else begin
                pad_byte = 8'h00;
            end
            // Trailing 8 bytes carry the big-endian message bit length.
            if (k >= LEN_FIELD_BYTE) begin
                pad_byte = bit_len[8*((BUF_BYTES-1-k) % 8) +: 8];
            end
            data_o[byte_bit_lo(k) +: 8] = pad_byte;
        end
    end

endmodule

// File: rtl/sha1_msg_padder.sv
// rtl/sha1_msg_padder.sv - byte-stream front end feeding the two-block SHA-1 core
module sha1_msg_padder
    import sha1_pkg::*;
#(
    parameter int RESTART_CYCLES = 16,
    parameter int MIN_BYTES      = 56,
    parameter int MAX_BYTES      = 119
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic [1023:0] data_out,
    output logic          restart,
    input  logic          sha_ready,
    input  logic          sha_valid,
    input  logic [159:0]  hash_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [159:0]  m_hash,
    output logic          err
);

    localparam int             RW       = $clog2(RESTART_CYCLES + 1);
    localparam logic [RW-1:0]  RST_LOAD = RW'(RESTART_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [1023:0] buf_q, buf_d;
    logic [1023:0] data_out_q, data_out_d;
    logic [1023:0] padded;
    logic          restart_q, restart_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          m_valid_q, m_valid_d;
    logic [159:0]  m_hash_q, m_hash_d;
    logic          err_q, err_d;
    logic          accept;

    assign s_ready  = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
    assign accept   = s_valid && s_ready;
    assign data_out = data_out_q;
    assign restart  = restart_q;
    assign m_valid  = m_valid_q;
    assign m_hash   = m_hash_q;
    assign err      = err_q;

    sha1_pad_pack u_pad_pack (
        .buf_i  (buf_q),
        .len_i  (cnt_q),
        .data_o (padded)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        data_out_d = data_out_q;
        restart_d  = restart_q;
        rcnt_d     = rcnt_q;
        m_valid_d  = m_valid_q;
        m_hash_d   = m_hash_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (accept) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = s_data;
                    cnt_d = cnt_q + 7'd1;
                    // A byte beyond the longest legal message is an error even when it is the last.
                    if (cnt_q >= 7'(MAX_BYTES)) begin
                        err_d   = 1'b1;
                        state_d = s_last ? ST_IDLE : ST_DRAIN;
                    end else if (s_last) begin
                        if (cnt_q < 7'(MIN_BYTES - 1)) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAD: begin
                data_out_d = padded;
                state_d    = ST_START;
            end
            ST_START: begin
                if (!restart_q) begin
                    if (sha_ready) begin
                        restart_d = 1'b1;
                        rcnt_d    = RST_LOAD;
                    end
                end else if (rcnt_q == '0) begin
                    restart_d = 1'b0;
                    state_d   = ST_WAIT;
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            ST_WAIT: begin
                if (sha_valid) begin
                    m_hash_d  = hash_in;
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            data_out_q <= '0;
            restart_q  <= 1'b0;
            rcnt_q     <= '0;
            m_valid_q  <= 1'b0;
            m_hash_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            data_out_q <= data_out_d;
            restart_q  <= restart_d;
            rcnt_q     <= rcnt_d;
            m_valid_q  <= m_valid_d;
            m_hash_q   <= m_hash_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb/tb_sha1_msg_padder.sv - directed-vector bench for sha1_msg_padder with a stub core
module tb_sha1_msg_padder;

    localparam logic [159:0] D1 = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [159:0] D2 = 160'h01234567_89abcdef_fedcba98_76543210_0badf00d;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid, s_ready, s_last;
    logic [7:0]    s_data;
    logic [1023:0] data_out;
    logic          restart, sha_ready, sha_valid;
    logic [159:0]  hash_in, m_hash;
    logic          m_valid, m_ready, err;

    int         n_vec = 0;
    int         n_bad = 0;
    int         restart_hi = 0;
    logic [7:0] msg [0:255];

    always #5 clk = ~clk;

    always @(negedge clk) if (restart) restart_hi++;

    sha1_msg_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .data_out  (data_out),
        .restart   (restart),
        .sha_ready (sha_ready),
        .sha_valid (sha_valid),
        .hash_in   (hash_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_hash    (m_hash),
        .err       (err)
    );

    task automatic check_vec(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dword(input int blk, input int w);
        return data_out[512*blk + 32*w +: 32];
    endfunction

    task automatic load_abc();
        string s;
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < 56; i++) msg[i] = s[i];
    endtask

    task automatic load_fill(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) msg[i] = b;
    endtask

    // Returns at the negedge right after the last byte is accepted.
    task automatic send_msg(input int n, output int err_at, output int err_cnt);
        int t;
        err_at  = -1;
        err_cnt = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == n - 1);
            t = 0;
            while (!s_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                check_vec("s_ready_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            if (err) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_hash(input logic [159:0] digest);
        int t, rc;
        t  = 0;
        rc = 0;
        while (!restart && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (restart && rc < 100) begin
            rc++;
            @(negedge clk);
        end
        check_vec("restart_cycles", rc, 16);
        @(negedge clk);
        sha_valid = 1'b1;
        hash_in   = digest;
        @(negedge clk);
        sha_valid = 1'b0;
        hash_in   = ~digest;
        check_vec("m_valid_set", m_valid, 1);
        check_vec("m_hash", m_hash, digest);
    endtask

    task automatic release_digest();
        m_ready = 1'b1;
        check_vec("m_valid_in_hs", m_valid, 1);
        @(negedge clk);
        m_ready = 1'b0;
        check_vec("m_valid_cleared", m_valid, 0);
    endtask

    initial begin
        int   ea, ec, r0, t;
        logic stable;
        s_valid = 0; s_data = 0; s_last = 0;
        sha_ready = 0; sha_valid = 0; hash_in = '0; m_ready = 0;
        repeat (3) @(negedge clk);
        check_vec("rst_s_ready", s_ready, 0);
        check_vec("rst_restart", restart, 0);
        check_vec("rst_m_valid", m_valid, 0);
        check_vec("rst_err", err, 0);
        check_vec("rst_dout_or", {159'd0, |data_out}, 0);
        check_vec("rst_m_hash", m_hash, 0);
        rst_n = 1'b1;

        @(negedge clk);
        sha_valid = 1'b1;
        hash_in   = '1;
        @(negedge clk);
        sha_valid = 1'b0;
        check_vec("stray_sha_valid", m_valid, 0);
        sha_ready = 1'b1;

        // 56-byte reference message, latency, padding, stall and handshake
        load_abc();
        send_msg(56, ea, ec);
        check_vec("abc_no_err", ec, 0);
        @(negedge clk);
        check_vec("abc_b0w0", dword(0, 0), 32'h61626364);
        check_vec("abc_b0w13", dword(0, 13), 32'h6e6f7071);
        check_vec("abc_b0w14", dword(0, 14), 32'h80000000);
        check_vec("abc_b1w15", dword(1, 15), 32'h000001c0);
        check_vec("restart_at_n1", restart, 0);
        @(negedge clk);
        check_vec("restart_at_n2", restart, 1);
        finish_hash(D1);
        check_vec("dout_held", dword(0, 0), 32'h61626364);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_hash !== D1 || s_ready !== 1'b0) stable = 1'b0;
        end
        check_vec("stall_stable", stable, 1);
        release_digest();

        // 119-byte maximum-length message
        load_fill(8'h61, 119);
        send_msg(119, ea, ec);
        @(negedge clk);
        check_vec("max_b0w0", dword(0, 0), 32'h61616161);
        check_vec("max_b1w13", dword(1, 13), 32'h61616180);
        check_vec("max_b1w14", dword(1, 14), 32'h00000000);
        check_vec("max_b1w15", dword(1, 15), 32'h000003b8);
        finish_hash(D2);
        release_digest();

        // 55-byte short message
        load_abc();
        r0 = restart_hi;
        send_msg(55, ea, ec);
        check_vec("short_err_at", ea, 54);
        check_vec("short_err_cnt", ec, 1);
        @(negedge clk);
        check_vec("short_err_pulse", err, 0);
        check_vec("short_collect", s_ready, 1);
        repeat (20) @(negedge clk);
        check_vec("short_no_restart", restart_hi - r0, 0);

        // 130-byte over-length message, then recovery
        for (int i = 0; i < 130; i++) msg[i] = 8'(i);
        r0 = restart_hi;
        send_msg(130, ea, ec);
        check_vec("long_err_at", ea, 119);
        check_vec("long_err_cnt", ec, 1);
        check_vec("long_idle", s_ready, 0);
        check_vec("long_no_restart", restart_hi - r0, 0);
        load_abc();
        send_msg(56, ea, ec);
        @(negedge clk);
        check_vec("recov_b0w0", dword(0, 0), 32'h61626364);
        check_vec("recov_b1w15", dword(1, 15), 32'h000001c0);
        finish_hash(D1);
        release_digest();

        // Reset during the 8th restart cycle
        load_abc();
        send_msg(56, ea, ec);
        t = 0;
        while (!restart && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (7) @(negedge clk);
        check_vec("restart_8th", restart, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_vec("midrst_restart", restart, 0);
        check_vec("midrst_m_valid", m_valid, 0);
        check_vec("midrst_dout_or", {159'd0, |data_out}, 0);
        rst_n = 1'b1;
        load_fill(8'h61, 119);
        send_msg(119, ea, ec);
        @(negedge clk);
        check_vec("post_b1w15", dword(1, 15), 32'h000003b8);
        finish_hash(D2);
        release_digest();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
